// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the capture block and the VGA generator.
package vga_timing_pkg;

   // Raster timing (pixel clocks per line, lines per frame, sync widths)
   localparam int H_TOTAL_DEF  = 165;
   localparam int H_SYNC_DEF   = 4;
   localparam int V_TOTAL_DEF  = 750;
   localparam int V_SYNC_DEF   = 5;

   // Active picture placement as emitted by the generator
   localparam int H_DATA_START = 26;
   localparam int V_DATA_START = 65;
   localparam int PIX_CLKS     = 2;
   localparam int ROW_LINES    = 20;

   // Reconstructed frame geometry
   localparam int DISP_COLS    = 64;
   localparam int DISP_ROWS    = 32;
   localparam int DISP_BITS    = DISP_COLS * DISP_ROWS;

   // Sample points: one pixel past the data start horizontally, and the
   // middle line of each 20-line row band vertically (28 and 75).
   localparam int CAP_H_START  = H_DATA_START + PIX_CLKS;
   localparam int CAP_V_START  = V_DATA_START + ROW_LINES / 2;

   typedef enum logic {
      ST_UNLOCKED,
      ST_CAPTURE
   } cap_state_t;

endpackage

// File: rtl/vga_sync_sampler.sv
// Registers color/hsync/vsync once and flags sync edges on the sampled values.
module vga_sync_sampler (
   input  logic pixel_clk_7_425mhz,
   input  logic rst,
   input  logic color,
   input  logic hsync,
   input  logic vsync,
   output logic color_s,
   output logic hsync_fall,
   output logic hsync_rise,
   output logic vsync_fall,
   output logic vsync_rise
);

   logic hsync_s;
   logic vsync_s;
   logic hsync_d;
   logic vsync_d;

   // sample inputs once and keep the previous sampled sync levels
   always_ff @(posedge pixel_clk_7_425mhz) begin
      if (rst) begin
         color_s <= 1'b0;
         hsync_s <= 1'b0;
         vsync_s <= 1'b0;
         hsync_d <= 1'b0;
         vsync_d <= 1'b0;
      end else begin
         color_s <= color;
         hsync_s <= hsync;
         vsync_s <= vsync;
         hsync_d <= hsync_s;
         vsync_d <= vsync_s;
      end
   end

   assign hsync_fall = hsync_d & ~hsync_s;
   assign hsync_rise = ~hsync_d & hsync_s;
   assign vsync_fall = vsync_d & ~vsync_s;
   assign vsync_rise = ~vsync_d & vsync_s;

endmodule

// File: rtl/vga_capture.sv
// Locks onto a fixed-timing 1-bit VGA stream and rebuilds a 64x32 frame.
module vga_capture
   import vga_timing_pkg::*;
#(
   parameter int H_TOTAL = H_TOTAL_DEF,
   parameter int H_SYNC  = H_SYNC_DEF,
   parameter int V_TOTAL = V_TOTAL_DEF,
   parameter int V_SYNC  = V_SYNC_DEF
) (
   input  logic                 pixel_clk_7_425mhz,
   input  logic                 rst,
   input  logic                 color,
   input  logic                 hsync,
   input  logic                 vsync,
   output logic [DISP_BITS-1:0] display,
   output logic                 frame_valid,
   output logic                 locked,
   output logic                 sync_error
);

   localparam logic [7:0] H_TOTAL_C     = 8'(H_TOTAL);
   localparam logic [7:0] H_SYNC_C      = 8'(H_SYNC);
   localparam logic [9:0] V_TOTAL_C     = 10'(V_TOTAL);
   localparam logic [9:0] V_LAST_C      = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_SYNC_C      = 10'(V_SYNC);
   localparam logic [7:0] CAP_H_START_C = 8'(CAP_H_START);

   logic                 color_s;
   logic                 hsync_fall;
   logic                 hsync_rise;
   logic                 vsync_fall;
   logic                 vsync_rise;

   logic [7:0]           h_cnt;
   logic [7:0]           pos;
   logic [9:0]           line_idx;
   logic [9:0]           line_next;
   logic [7:0]           col_off;
   logic [5:0]           col_idx;
   logic [4:0]           row_idx;
   logic                 col_hit;
   logic                 row_hit;
   logic [DISP_BITS-1:0] shadow;
   cap_state_t           state_q;
   cap_state_t           state_d;
   logic                 err;
   logic                 commit;

   vga_sync_sampler u_sampler (
      .pixel_clk_7_425mhz (pixel_clk_7_425mhz),
      .rst                (rst),
      .color              (color),
      .hsync              (hsync),
      .vsync              (vsync),
      .color_s            (color_s),
      .hsync_fall         (hsync_fall),
      .hsync_rise         (hsync_rise),
      .vsync_fall         (vsync_fall),
      .vsync_rise         (vsync_rise)
   );

   // line position and the index of the line this cycle belongs to
   always_comb begin
      pos       = hsync_fall ? '0 : h_cnt;
      line_next = line_idx;
      if (hsync_fall) begin
         if (vsync_fall) begin
            line_next = '0;
         end else if (line_idx != '1) begin
            line_next = line_idx + 10'd1;
         end
      end
   end

   // horizontal clock counter and line counter, both saturating
   always_ff @(posedge pixel_clk_7_425mhz) begin
      if (rst) begin
         h_cnt    <= '0;
         line_idx <= '0;
      end else begin
         if (hsync_fall) begin
            h_cnt <= 8'd1;
         end else if (h_cnt != '1) begin
            h_cnt <= h_cnt + 8'd1;
         end
         line_idx <= line_next;
      end
   end

   // map (line, position) onto a display sample point
   always_comb begin
      col_off = pos - CAP_H_START_C;
      col_idx = col_off[6:1];
      col_hit = (pos >= CAP_H_START_C) && !col_off[0] && (col_off[7:1] < 7'(DISP_COLS));
      row_hit = 1'b0;
      row_idx = '0;
      for (int unsigned r = 0; r < DISP_ROWS; r++) begin
         if (line_next == 10'(CAP_V_START + r * ROW_LINES)) begin
            row_hit = 1'b1;
            row_idx = 5'(r);
         end
      end
   end

   // lock FSM: timing checks while capturing, commit on a clean frame end
   always_comb begin
      state_d = state_q;
      err     = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_UNLOCKED: begin
            if (vsync_fall) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            err = (hsync_fall && (h_cnt != H_TOTAL_C))
               || (hsync_rise && (h_cnt != H_SYNC_C))
               || (vsync_rise && !(hsync_fall && (line_next == V_SYNC_C)))
               || (vsync_fall && !hsync_fall)
               || (hsync_fall && (line_next == V_TOTAL_C));
            commit = vsync_fall && (line_idx == V_LAST_C) && !err;
            if (err) begin
               state_d = ST_UNLOCKED;
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

   // FSM state register
   always_ff @(posedge pixel_clk_7_425mhz) begin
      if (rst) begin
         state_q <= ST_UNLOCKED;
      end else begin
         state_q <= state_d;
      end
   end

   // shadow frame: column k lands at bit 63-k, i.e. the inverted column index
   always_ff @(posedge pixel_clk_7_425mhz) begin
      if (rst) begin
         shadow <= '0;
      end else if ((state_q == ST_CAPTURE) && row_hit && col_hit) begin
         shadow[{row_idx, ~col_idx}] <= color_s;
      end
   end

   // output registers: errors override commits, display holds on error
   always_ff @(posedge pixel_clk_7_425mhz) begin
      if (rst) begin
         display     <= '0;
         frame_valid <= 1'b0;
         locked      <= 1'b0;
         sync_error  <= 1'b0;
      end else begin
         frame_valid <= commit;
         sync_error  <= err;
         if (err) begin
            locked <= 1'b0;
         end else if (commit) begin
            locked <= 1'b1;
         end
         if (commit) begin
            display <= shadow;
         end
      end
   end

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture: random frames with a frame-level model.
module tb_vga_capture;
   import vga_timing_pkg::*;

   localparam int HT = 165;
   localparam int HS = 4;
   localparam int VT = 750;
   localparam int VS = 5;

   localparam int F_NONE    = 0;
   localparam int F_STRETCH = 1;
   localparam int F_SHORT   = 2;
   localparam int F_RESET   = 3;

   logic                 pixel_clk_7_425mhz = 1'b0;
   logic                 rst   = 1'b1;
   logic                 color = 1'b0;
   logic                 hsync = 1'b1;
   logic                 vsync = 1'b1;
   logic [DISP_BITS-1:0] display;
   logic                 frame_valid;
   logic                 locked;
   logic                 sync_error;

   vga_capture #(
      .H_TOTAL (HT),
      .H_SYNC  (HS),
      .V_TOTAL (VT),
      .V_SYNC  (VS)
   ) dut (
      .pixel_clk_7_425mhz (pixel_clk_7_425mhz),
      .rst                (rst),
      .color              (color),
      .hsync              (hsync),
      .vsync              (vsync),
      .display            (display),
      .frame_valid        (frame_valid),
      .locked             (locked),
      .sync_error         (sync_error)
   );

   always #5 pixel_clk_7_425mhz = ~pixel_clk_7_425mhz;

   int n_checks = 0;
   int n_bad    = 0;
   int n_fv_seen  = 0;
   int n_err_seen = 0;
   int n_fv_exp   = 0;
   int n_err_exp  = 0;

   // frame-level reference model
   logic                 in_capture  = 1'b0;
   logic                 exp_locked  = 1'b0;
   logic [DISP_BITS-1:0] exp_display = '0;
   logic [DISP_BITS-1:0] frame_img   = '0;
   logic [DISP_BITS-1:0] ev_img      = '0;
   logic [DISP_BITS-1:0] pend_img    = '0;
   logic                 pend_fv     = 1'b0;
   logic                 pend_err    = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_display();
      for (int r = 0; r < 32; r++) begin
         check_val($sformatf("display_row%0d", r), display[r*64 +: 64], exp_display[r*64 +: 64]);
      end
   endtask

   // pixel (r,k) is sampled on line 75+20r at line position 28+2k
   function automatic bit cap_point(input int l, input int x, output int idx);
      int r;
      int k;
      idx = 0;
      if (l < 75 || x < 28) return 1'b0;
      if (((l - 75) % 20) != 0 || ((x - 28) % 2) != 0) return 1'b0;
      r = (l - 75) / 20;
      k = (x - 28) / 2;
      if (r >= 32 || k >= 64) return 1'b0;
      idx = r * 64 + 63 - k;
      return 1'b1;
   endfunction

   function automatic logic [DISP_BITS-1:0] rand_img();
      logic [DISP_BITS-1:0] v;
      for (int i = 0; i < DISP_BITS / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // one pixel clock: drive, observe after the edge, queue this cycle's events
   task automatic step(input logic r, input logic ev_fv, input logic ev_err, input logic probe);
      logic obs_fv;
      logic obs_err;
      rst = r;
      @(posedge pixel_clk_7_425mhz);
      #1;
      obs_fv  = pend_fv & ~r;
      obs_err = pend_err & ~r;
      if (r) begin
         exp_locked  = 1'b0;
         exp_display = '0;
      end else begin
         if (obs_err) exp_locked = 1'b0;
         if (obs_fv) begin
            exp_locked  = 1'b1;
            exp_display = pend_img;
         end
      end
      if (r || frame_valid || obs_fv) check_val("frame_valid", 64'(frame_valid), 64'(obs_fv));
      if (r || sync_error || obs_err) check_val("sync_error", 64'(sync_error), 64'(obs_err));
      if (r || probe || obs_fv || obs_err) check_val("locked", 64'(locked), 64'(exp_locked));
      if (r || obs_fv || obs_err) check_display();
      if (frame_valid) n_fv_seen++;
      if (sync_error) n_err_seen++;
      pend_fv  = ev_fv & ~r;
      pend_err = ev_err & ~r;
      if (ev_fv) pend_img = ev_img;
   endtask

   // generate one frame of timing-correct video with an optional fault
   task automatic run_frame(input logic [DISP_BITS-1:0] img, input int fault,
                            input int fault_line, input int n_lines);
      int   len;
      int   low;
      int   idx;
      logic r;
      logic efv;
      logic eerr;
      for (int l = 0; l < n_lines; l++) begin
         len = (fault == F_STRETCH && l == fault_line) ? HT + 1 : HT;
         low = (fault == F_SHORT && l == fault_line) ? 3 : HS;
         for (int x = 0; x < len; x++) begin
            r    = 1'b0;
            efv  = 1'b0;
            eerr = 1'b0;
            hsync = (x >= low);
            vsync = (l >= VS);
            if (cap_point(l, x, idx)) color = img[idx];
            else color = 1'($urandom);
            if (l == 0 && x == 0) begin
               if (in_capture) begin
                  efv    = 1'b1;
                  ev_img = frame_img;
                  n_fv_exp++;
               end else begin
                  in_capture = 1'b1;
               end
               frame_img = img;
            end
            if (in_capture &&
                ((fault == F_STRETCH && l == fault_line + 1 && x == 0) ||
                 (fault == F_SHORT && l == fault_line && x == low))) begin
               eerr       = 1'b1;
               in_capture = 1'b0;
               n_err_exp++;
            end
            if (fault == F_RESET && l == fault_line && x == 0) begin
               r          = 1'b1;
               in_capture = 1'b0;
            end
            step(r, efv, eerr, x == 0);
         end
      end
   endtask

   initial begin
      logic [DISP_BITS-1:0] img_a;
      logic [DISP_BITS-1:0] img_b;

      img_a = '0;
      img_a[2047] = 1'b1;
      img_a[0]    = 1'b1;
      img_b = '0;
      for (int r = 0; r < 32; r++)
         for (int k = 0; k < 64; k++)
            img_b[r*64 + 63 - k] = 1'((r + k) % 2);

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

      run_frame(img_a,      F_NONE,    0,   VT);  // first vsync fall: lock entry
      run_frame(img_b,      F_NONE,    0,   VT);  // commits corner-bit frame
      run_frame(rand_img(), F_NONE,    0,   VT);  // commits checkerboard
      run_frame(rand_img(), F_STRETCH, 400, VT);  // commits, then long line
      run_frame(rand_img(), F_NONE,    0,   VT);  // re-entry only
      run_frame(rand_img(), F_RESET,   300, VT);  // commits, then reset
      run_frame(rand_img(), F_NONE,    0,   VT);  // re-entry only
      run_frame(rand_img(), F_SHORT,   100, VT);  // commits, then short hsync
      run_frame(rand_img(), F_NONE,    0,   12);  // no commit after the error

      check_val("frame_valid_count", 64'(n_fv_seen), 64'(n_fv_exp));
      check_val("sync_error_count", 64'(n_err_seen), 64'(n_err_exp));
      check_val("locked_final", 64'(locked), 64'(exp_locked));
      check_display();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
